// File: rtl/gpio_regs.sv
// GPIO register file: pad data/tristate control, synchronised pin readback,
// per-pin edge-detect interrupts with sticky W1C status and a masked irq line.

// Per-pin input path: synchroniser chain, previous-value flop, edge filter.
module gpio_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic edge_sel,
  input  logic both_sel,
  input  logic det_en,
  output logic sync_val,
  output logic det
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise, fall;

  // Shift the raw pin through the synchroniser and keep one previous sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  // Select which transition counts as an event; both-edge mode overrides edge_sel.
  always_comb begin
    rise = sync_val & ~prev_q;
    fall = ~sync_val & prev_q;
    det  = 1'b0;
    if (det_en) begin
      if (both_sel)      det = rise | fall;
      else if (edge_sel) det = fall;
      else               det = rise;
    end
  end
endmodule

module gpio_regs #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:2]       addr,
  input  logic [3:0]       wben,
  input  logic             r_wn,
  input  logic [31:0]      wdata,
  input  logic [WIDTH-1:0] ro_gpio_pinstate,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] rf_gpio_datareg,
  output logic [WIDTH-1:0] rf_gpio_tristate,
  output logic [WIDTH-1:0] rf_gpio_interrupt_mask,
  output logic             irq
);
  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_TRI    = 3'd1;
  localparam logic [2:0] A_PIN    = 3'd2;
  localparam logic [2:0] A_MASK   = 3'd3;
  localparam logic [2:0] A_EDGE   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_BOTH   = 3'd6;
  localparam logic [2:0] A_CONFIG = 3'd7;

  logic [WIDTH-1:0] data_q, tri_q, mask_q, edge_q, both_q, status_q;
  logic [WIDTH-1:0] pin_sync, pin_det;
  logic [WIDTH-1:0] wbits, w1c;
  logic [31:0]      wmask32, rd_val;
  logic [2:0]       settle_q;
  logic             det_en, wr;
  logic             unused_bits;

  assign wr     = ~r_wn;
  assign det_en = (settle_q == 3'd0);

  // Byte enables expanded to a bit mask; only the low WIDTH bits reach registers.
  always_comb begin
    wmask32 = '0;
    for (int n = 0; n < 4; n++) wmask32[8*n +: 8] = {8{wben[n]}};
  end

  assign wbits       = wmask32[WIDTH-1:0];
  assign w1c         = (wr && addr == A_STATUS) ? (wdata[WIDTH-1:0] & wbits) : '0;
  assign unused_bits = ^{wdata, wmask32};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old);
    return (old & ~wbits) | (wdata[WIDTH-1:0] & wbits);
  endfunction

  gpio_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin [WIDTH-1:0] (
    .clk      (clk),
    .reset    (reset),
    .pin      (ro_gpio_pinstate),
    .edge_sel (edge_q),
    .both_sel (both_q),
    .det_en   (det_en),
    .sync_val (pin_sync),
    .det      (pin_det)
  );

  // Settle counter holds off edge detection while the sync/prev flops fill after reset.
  always_ff @(posedge clk) begin
    if (!reset)               settle_q <= 3'(SYNC_STAGES + 1);
    else if (settle_q != 3'd0) settle_q <= settle_q - 3'd1;
  end

  // Control registers with byte-lane writes; status is sticky, set beats clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q   <= '0;
      tri_q    <= '1;
      mask_q   <= '0;
      edge_q   <= '0;
      both_q   <= '0;
      status_q <= '0;
    end else begin
      if (wr && addr == A_DATA) data_q <= merge(data_q);
      if (wr && addr == A_TRI)  tri_q  <= merge(tri_q);
      if (wr && addr == A_MASK) mask_q <= merge(mask_q);
      if (wr && addr == A_EDGE) edge_q <= merge(edge_q);
      if (wr && addr == A_BOTH) both_q <= merge(both_q);
      status_q <= (status_q & ~w1c) | pin_det;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_val = '0;
    case (addr)
      A_DATA:   rd_val[WIDTH-1:0] = data_q;
      A_TRI:    rd_val[WIDTH-1:0] = tri_q;
      A_PIN:    rd_val[WIDTH-1:0] = pin_sync;
      A_MASK:   rd_val[WIDTH-1:0] = mask_q;
      A_EDGE:   rd_val[WIDTH-1:0] = edge_q;
      A_STATUS: rd_val[WIDTH-1:0] = status_q;
      A_BOTH:   rd_val[WIDTH-1:0] = both_q;
      A_CONFIG: rd_val = {16'h6710, 8'(SYNC_STAGES), 8'(WIDTH)};
      default:  rd_val = '0;
    endcase
  end

  // Registered read data (held during writes) and registered masked interrupt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (r_wn) rdata <= rd_val;
      irq <= |(status_q & mask_q);
    end
  end

  assign rf_gpio_datareg        = data_q;
  assign rf_gpio_tristate       = tri_q;
  assign rf_gpio_interrupt_mask = mask_q;
endmodule

// File: tb/tb_gpio_regs.sv
// Bench for gpio_regs: directed vector table plus randomized traffic, both
// checked every cycle against a history-based reference model.
module tb_gpio_regs;
  localparam int W = 16;
  localparam int S = 2;
  localparam logic [2:0] CR = 3'b001, CD = 3'b010, CI = 3'b100;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    addr;
  logic [3:0]    wben;
  logic          r_wn;
  logic [31:0]   wdata;
  logic [W-1:0]  pins;
  logic [31:0]   rdata;
  logic [W-1:0]  datareg, tristate, imask;
  logic          irq;

  gpio_regs #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wben(wben), .r_wn(r_wn),
    .wdata(wdata), .ro_gpio_pinstate(pins), .rdata(rdata),
    .rf_gpio_datareg(datareg), .rf_gpio_tristate(tristate),
    .rf_gpio_interrupt_mask(imask), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pin history queue, newest sample at index 0.
  logic [W-1:0] m_data, m_tri, m_mask, m_edge, m_both, m_status;
  logic [31:0]  m_rdata;
  logic         m_irq;
  logic [W-1:0] smp[$];
  int           since;

  task automatic model_step();
    logic [31:0]  rd, bm;
    logic [W-1:0] s, p, rise, fall, det, wv, wm;
    logic         nirq;
    if (!reset) begin
      m_data = '0; m_tri = '1; m_mask = '0; m_edge = '0; m_both = '0;
      m_status = '0; m_rdata = '0; m_irq = 1'b0;
      smp.delete();
      for (int i = 0; i <= S; i++) smp.push_back('0);
      since = 0;
    end else begin
      s = smp[S-1];
      p = smp[S];
      case (addr)
        3'd0: rd = {16'h0, m_data};
        3'd1: rd = {16'h0, m_tri};
        3'd2: rd = {16'h0, s};
        3'd3: rd = {16'h0, m_mask};
        3'd4: rd = {16'h0, m_edge};
        3'd5: rd = {16'h0, m_status};
        3'd6: rd = {16'h0, m_both};
        default: rd = 32'h67100210;
      endcase
      rise = s & ~p;
      fall = ~s & p;
      det  = (m_both & (rise | fall)) | (~m_both & m_edge & fall) | (~m_both & ~m_edge & rise);
      if (since < S + 1) det = '0;
      nirq = |(m_status & m_mask);
      bm = '0;
      for (int n = 0; n < 4; n++) if (wben[n]) bm[8*n +: 8] = 8'hFF;
      wv = wdata[W-1:0];
      wm = bm[W-1:0];
      if (!r_wn) begin
        case (addr)
          3'd0: m_data   = (m_data & ~wm) | (wv & wm);
          3'd1: m_tri    = (m_tri  & ~wm) | (wv & wm);
          3'd3: m_mask   = (m_mask & ~wm) | (wv & wm);
          3'd4: m_edge   = (m_edge & ~wm) | (wv & wm);
          3'd5: m_status = m_status & ~(wv & wm);
          3'd6: m_both   = (m_both & ~wm) | (wv & wm);
          default: ;
        endcase
      end
      m_status = m_status | det;
      if (r_wn) m_rdata = rd;
      m_irq = nirq;
      smp.push_front(pins);
      void'(smp.pop_back());
      if (since < 1000) since++;
    end
  endtask

  task automatic model_cmp(input string tag);
    chk({tag, " rdata"}, rdata, m_rdata);
    chk({tag, " datareg"}, {16'h0, datareg}, {16'h0, m_data});
    chk({tag, " tristate"}, {16'h0, tristate}, {16'h0, m_tri});
    chk({tag, " mask"}, {16'h0, imask}, {16'h0, m_mask});
    chk({tag, " irq"}, {31'h0, irq}, {31'h0, m_irq});
  endtask

  typedef struct {
    logic        rst_n;
    logic        r_wn;
    logic [2:0]  addr;
    logic [3:0]  wben;
    logic [31:0] wdata;
    logic [W-1:0] pins;
    logic [2:0]  ck;
    logic [31:0] e_rdata;
    logic [W-1:0] e_data;
    logic        e_irq;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rn, input logic rw, input logic [2:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [W-1:0] pn, input logic [2:0] ck,
                     input logic [31:0] er, input logic [W-1:0] ed, input logic ei);
    vec_t v;
    v.rst_n = rn; v.r_wn = rw; v.addr = a; v.wben = be; v.wdata = wd; v.pins = pn;
    v.ck = ck; v.e_rdata = er; v.e_data = ed; v.e_irq = ei;
    vt.push_back(v);
  endtask

  initial begin
    // reset defaults
    add(0,1,0,0,0,0, CR|CD|CI, 0,0,0);
    add(0,1,0,0,0,0, CR|CD|CI, 0,0,0);
    add(1,1,0,0,0,0, CR|CD|CI, 0,0,0);
    add(1,1,1,0,0,0, CR, 32'h0000FFFF,0,0);
    for (int a = 2; a <= 6; a++) add(1,1,3'(a),0,0,0, CR, 0,0,0);
    add(1,1,7,0,0,0, CR, 32'h67100210,0,0);
    // byte-lane writes to DATA
    add(1,0,0,4'b0001,32'hFFFF9249,0, CR|CD, 32'h67100210,16'h0049,0);
    add(1,0,0,4'b0010,32'hFFFF9249,0, CD, 0,16'h9249,0);
    add(1,0,0,4'b0000,32'hFFFF9249,0, CD, 0,16'h9249,0);
    add(1,1,0,0,0,0, CR|CD, 32'h00009249,16'h9249,0);
    // rising edge on pin0 with mask bit0
    add(1,0,3,4'hF,32'h1,0, 0, 0,0,0);
    add(1,1,5,0,0,16'h1, CR, 0,0,0);
    add(1,1,2,0,0,16'h1, CR, 0,0,0);
    add(1,1,5,0,0,16'h1, CR|CI, 0,0,0);
    add(1,1,5,0,0,16'h1, CR|CI, 32'h1,0,1);
    add(1,0,5,4'h1,32'h1,16'h1, CI, 0,0,1);
    add(1,1,5,0,0,16'h1, CR|CI, 0,0,0);
    // falling on pin1, both on pin2
    add(1,0,4,4'hF,32'h2,16'h1, 0, 0,0,0);
    add(1,0,6,4'hF,32'h4,16'h1, 0, 0,0,0);
    add(1,1,5,0,0,16'h7, CR, 0,0,0);
    add(1,1,5,0,0,16'h7, CR, 0,0,0);
    add(1,1,5,0,0,16'h7, CR|CI, 0,0,0);
    add(1,1,5,0,0,16'h7, CR|CI, 32'h4,0,0);
    add(1,0,5,4'h1,32'h4,16'h3, 0, 0,0,0);
    add(1,1,5,0,0,16'h3, CR, 0,0,0);
    add(1,1,5,0,0,16'h3, CR, 0,0,0);
    add(1,1,5,0,0,16'h1, CR, 32'h4,0,0);
    add(1,0,5,4'h1,32'h4,16'h1, 0, 0,0,0);
    add(1,1,5,0,0,16'h1, CR, 0,0,0);
    add(1,1,5,0,0,16'h1, CR|CI, 32'h2,0,0);
    // masked pin3 sets status, irq stays low
    add(1,1,5,0,0,16'h9, CR, 32'h2,0,0);
    add(1,1,5,0,0,16'h9, CR, 32'h2,0,0);
    add(1,1,5,0,0,16'h9, CR, 32'h2,0,0);
    add(1,1,5,0,0,16'h9, CR|CI, 32'hA,0,0);
    add(1,0,5,4'h1,32'hFF,16'h9, CI, 0,0,0);
    // set-wins: W1C of bit0 on the same edge pin0 rises into status
    add(1,1,5,0,0,16'h8, CR, 0,0,0);
    add(1,1,5,0,0,16'h8, CR, 0,0,0);
    add(1,1,5,0,0,16'h8, CR, 0,0,0);
    add(1,1,5,0,0,16'h9, CR, 0,0,0);
    add(1,1,5,0,0,16'h9, CR, 0,0,0);
    add(1,0,5,4'h1,32'h1,16'h9, 0, 0,0,0);
    add(1,1,5,0,0,16'h9, CR|CI, 32'h1,0,1);
    // reset mid-write with pins high, then no spurious edges
    add(1,1,0,0,0,16'hFFFF, CR|CD, 32'h9249,16'h9249,0);
    add(0,0,0,4'hF,32'h1234,16'hFFFF, CR|CD|CI, 0,0,0);
    for (int i = 0; i < 4; i++) add(1,1,5,0,0,16'hFFFF, CR|CI, 0,0,0);
    add(1,1,3,0,0,16'hFFFF, CR|CD|CI, 0,0,0);
    add(1,1,2,0,0,16'hFFFF, CR, 32'h0000FFFF,0,0);
    add(1,1,5,0,0,16'hFFFF, CR|CI, 0,0,0);

    reset = 1'b0; r_wn = 1'b1; addr = '0; wben = '0; wdata = '0; pins = '0;
    smp.delete();

    foreach (vt[i]) begin
      reset = vt[i].rst_n; r_wn = vt[i].r_wn; addr = vt[i].addr;
      wben = vt[i].wben; wdata = vt[i].wdata; pins = vt[i].pins;
      @(posedge clk);
      model_step();
      #1;
      model_cmp($sformatf("vec%0d model", i));
      if (vt[i].ck[0]) chk($sformatf("vec%0d rdata", i), rdata, vt[i].e_rdata);
      if (vt[i].ck[1]) chk($sformatf("vec%0d datareg", i), {16'h0, datareg}, {16'h0, vt[i].e_data});
      if (vt[i].ck[2]) chk($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, vt[i].e_irq});
    end

    // randomized traffic with occasional resets and sparse pin changes
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      r_wn  = 1'($urandom_range(0, 1));
      addr  = 3'($urandom_range(0, 7));
      wben  = 4'($urandom);
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) pins = W'($urandom);
      @(posedge clk);
      model_step();
      #1;
      model_cmp($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_regs.md
# gpio_regs

Parametrised GPIO register file, the successor to the fixed 16-pin `register` block. It sits between the bus slave decoder and the GPIO pad ring. It adds a configurable pin count, an input synchroniser, and per-pin edge-detect interrupts with a sticky write-1-to-clear status register. It also drives a single masked interrupt line to the interrupt controller.

## Interface
- `WIDTH`, 16: number of GPIO pins, 1..32. Register bits at or above `WIDTH` read 0 and ignore writes.
- `SYNC_STAGES`, 2: depth of the pin-input synchroniser, 2..3.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `addr` input [4:2]: word address of the register.
- `wben` input [3:0]: byte write enables; bit n covers `wdata[8n+7:8n]`.
- `r_wn` input 1: 1 = read, 0 = write.
- `wdata` input [31:0]: write data.
- `ro_gpio_pinstate` input [WIDTH-1:0]: raw, asynchronous pin levels.
- `rdata` output [31:0]: registered read data.
- `rf_gpio_datareg` output [WIDTH-1:0]: output data to pads.
- `rf_gpio_tristate` output [WIDTH-1:0]: 1 = pin is an input (driver off).
- `rf_gpio_interrupt_mask` output [WIDTH-1:0]: 1 = pin interrupt enabled.
- `irq` output 1: registered, OR of (status AND mask).

## Operation
- Register map (`addr`):
  - 0 DATA, RW
  - 1 TRISTATE, RW
  - 2 PINSTATE, RO: synchronised pins
  - 3 IRQ_MASK, RW
  - 4 IRQ_EDGE, RW: 0 = rising, 1 = falling
  - 5 IRQ_STATUS, R/W1C
  - 6 IRQ_BOTH, RW: 1 = both edges, overrides IRQ_EDGE
  - 7 CONFIG, RO: value {16'h6710, 8'd`SYNC_STAGES`, 8'd`WIDTH`}
- Write occurs when `r_wn`=0. Only lanes with `wben` bit set are updated. `wben`=0 with `r_wn`=0 is a no-op.
- Writes to RO addresses 2 and 7 are ignored.
- IRQ_STATUS is write-1-to-clear per enabled byte lane; writing 0 bits leaves them unchanged.
- Read occurs when `r_wn`=1: `rdata` loads the addressed register on the next edge. While `r_wn`=0, `rdata` holds its last value.
- Synchroniser: `SYNC_STAGES` flops per pin, followed by one "previous" flop.
- An edge is detected when the synchronised value differs from the previous value, filtered by IRQ_EDGE/IRQ_BOTH for that pin.
- A detected edge sets the IRQ_STATUS bit regardless of mask. The mask gates only `irq`.
- Simultaneous edge detect and W1C on the same bit: set wins, and the bit stays 1.
- Post-reset settle counter: after `reset` deasserts, edge detection is suppressed for `SYNC_STAGES`+1 cycles while the synchroniser and previous flops fill. This prevents spurious edges from pins already high.
- Reset values (`reset`=0 on an edge) take effect on that edge:
  - DATA = 0, TRISTATE = all ones, MASK = 0, EDGE = 0, BOTH = 0, STATUS = 0
  - sync and previous flops = 0, `rdata` = 0, `irq` = 0, settle counter loaded
- Reset asserted mid-operation aborts any write in that cycle and reinitialises all state as above.

## Timing
- Write: the register changes at the edge where `r_wn`=0 and `wben` is set. `rf_*` outputs reflect the new value immediately after that edge, with no added latency.
- Read latency is 1 cycle: `addr` is presented before edge k and `rdata` is valid after edge k.
- Read-after-write to the same address in consecutive cycles returns the new value.
- Pin to STATUS: a pin change stable before edge 1 appears in PINSTATE after edge `SYNC_STAGES`. The STATUS bit sets at edge `SYNC_STAGES`+1, and `irq` asserts at edge `SYNC_STAGES`+2.
- `irq` deasserts one cycle after the W1C edge, or after the edge at which the mask bit is cleared.
- Pulses shorter than one `clk` period may be missed; no requirement is placed on them.

## Test plan
- **Reset defaults:** hold `reset`=0 for 2 cycles and read addresses 0..7. DATA=0, TRISTATE=32'h0000FFFF (`WIDTH`=16), MASK/EDGE/STATUS/BOTH=0, CONFIG=32'h67100210, `irq`=0.
- **Byte-lane write:** with `r_wn`=0, `wdata`=32'hFFFF9249, write `wben`=4'b0001 then 4'b0010 to DATA. Expect `rf_gpio_datareg` 16'h0049, then 16'h9249. `wben`=0 leaves it unchanged, and a read with `r_wn`=1 returns 32'h00009249.
- **Rising-edge interrupt:** set MASK=16'h0001 and drive pin0 0→1. STATUS bit0=1 at edge 3 and `irq`=1 at edge 4 (`SYNC_STAGES`=2). Writing 32'h1 to STATUS clears it, and `irq`=0 on the next cycle.
- **Falling/both modes:** EDGE[1]=1 — pin1 1→0 sets bit1, and 0→1 does not. BOTH[2]=1 — both transitions of pin2 set bit2. Masked pin3 sets STATUS bit3 while `irq` stays 0.
- **Set-wins collision:** time a W1C of bit0 to land on the same edge as a new pin0 edge. STATUS bit0 remains 1.
- **Reset mid-operation and settle:** pins held at 16'hFFFF, pulse `reset` low for 1 cycle during a write. Write is discarded, all registers return to defaults, and STATUS stays 0 (no spurious edges after release).
